serial_nibble_adder: RTL and testbench

- Sequential controller that adds two wide operands one nibble per cycle using one external add_4 instance (ports in_0, in_1, cin, out, cout).
- Sits directly around add_4: drives its inputs and consumes its sum and carry outputs.
- Registers the ripple carry between nibbles and assembles the full-width result.
- Exposes a start/busy/done handshake to the datapath above.

---
 rtl/serial_nibble_adder.sv | 136 +++++++++++++
 tb/tb_serial_nibble_adder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_nibble_adder.sv
// Serial adder: sums two NIBBLES*4-bit operands one nibble per clock through an
// external combinational add_4, rippling the carry through a register.
module serial_nibble_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_op_a,
  input  logic [4*NIBBLES-1:0] i_op_b,
  input  logic                 i_cin,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4*NIBBLES-1:0] o_sum,
  output logic                 o_cout,
  output logic                 o_ovf,
  output logic [3:0]           o_add_in_0,
  output logic [3:0]           o_add_in_1,
  output logic                 o_add_cin,
  input  logic [3:0]           i_add_out,
  input  logic                 i_add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  // state  | meaning
  // S_IDLE | waiting for start; add_4 inputs held at 0
  // S_RUN  | one nibble through add_4 per cycle, carry registered
  // S_DONE | one-cycle done pulse; start ignored
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic          r_ovf;
  logic [IW-1:0] r_idx;

  logic [IW+1:0] w_shift;
  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [W-1:0]  w_nib_mask;
  logic [W-1:0]  w_nib_data;
  logic          w_accept;
  logic          w_last;

  assign w_shift    = {r_idx, 2'b00};
  assign w_a_nib    = 4'(r_a >> w_shift);
  assign w_b_nib    = 4'(r_b >> w_shift);
  assign w_nib_mask = W'(4'hF) << w_shift;
  assign w_nib_data = W'(i_add_out) << w_shift;
  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_last     = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_add_in_0  = 4'h0;
    o_add_in_1  = 4'h0;
    o_add_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy     = 1'b1;
        o_add_in_0 = w_a_nib;
        o_add_in_1 = w_b_nib;
        o_add_cin  = r_carry;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // sum is deliberately not cleared on accept; nibbles are overwritten in place
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= i_op_a;
      r_b     <= i_op_b;
      r_carry <= i_cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum   <= (r_sum & ~w_nib_mask) | w_nib_data;
      r_carry <= i_add_cout;
      if (w_last) begin
        r_cout <= i_add_cout;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (i_add_out[3] != r_a[W-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Bench for serial_nibble_adder: a 4-nibble and a 1-nibble instance share stimulus,
// each with a combinational add_4 model and an arithmetic reference model.
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;

  logic        busy4, done4, cout4, ovf4, acin4, acout4;
  logic [15:0] sum4;
  logic [3:0]  ain0_4, ain1_4, aout4;

  logic        busy1, done1, cout1, ovf1, acin1, acout1;
  logic [3:0]  sum1;
  logic [3:0]  ain0_1, ain1_1, aout1;
  logic [3:0]  op_a1, op_b1;

  assign op_a1 = op_a[3:0];
  assign op_b1 = op_b[3:0];

  assign {acout4, aout4} = 5'(ain0_4) + 5'(ain1_4) + 5'(acin4);
  assign {acout1, aout1} = 5'(ain0_1) + 5'(ain1_1) + 5'(acin1);

  always #5 clk = ~clk;

  serial_nibble_adder #(.NIBBLES(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_op_a(op_a), .i_op_b(op_b), .i_cin(cin),
    .o_busy(busy4), .o_done(done4), .o_sum(sum4), .o_cout(cout4), .o_ovf(ovf4),
    .o_add_in_0(ain0_4), .o_add_in_1(ain1_4), .o_add_cin(acin4),
    .i_add_out(aout4), .i_add_cout(acout4)
  );

  serial_nibble_adder #(.NIBBLES(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_op_a(op_a1), .i_op_b(op_b1), .i_cin(cin),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1), .o_ovf(ovf1),
    .o_add_in_0(ain0_1), .o_add_in_1(ain1_1), .o_add_cin(acin1),
    .i_add_out(aout1), .i_add_cout(acout1)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model state, one entry per instance (0: 4 nibbles, 1: 1 nibble)
  bit          m_run  [2];
  bit          m_done [2];
  int          m_k    [2];
  logic [63:0] m_a    [2];
  logic [63:0] m_b    [2];
  logic [63:0] m_full [2];
  logic [63:0] m_sum  [2];
  logic        m_cout [2];
  logic        m_ovf  [2];

  function automatic int nu(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic logic [63:0] msk(input int bits);
    if (bits >= 64) return '1;
    return (64'd1 << bits) - 64'd1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      int n;
      n = nu(u);
      if (!rst_n) begin
        m_run[u] = 1'b0; m_done[u] = 1'b0; m_k[u] = 0;
        m_a[u] = '0; m_b[u] = '0; m_full[u] = '0; m_sum[u] = '0;
        m_cout[u] = 1'b0; m_ovf[u] = 1'b0;
      end else if (m_done[u]) begin
        m_done[u] = 1'b0;
      end else if (m_run[u]) begin
        m_k[u]++;
        m_sum[u] = (m_full[u] & msk(4 * m_k[u])) | (m_sum[u] & ~msk(4 * m_k[u]));
        if (m_k[u] == n) begin
          m_run[u]  = 1'b0;
          m_done[u] = 1'b1;
          m_cout[u] = m_full[u][4*n];
          m_ovf[u]  = (m_a[u][4*n-1] == m_b[u][4*n-1]) && (m_full[u][4*n-1] != m_a[u][4*n-1]);
        end
      end else if (start) begin
        m_a[u]    = 64'(op_a) & msk(4 * n);
        m_b[u]    = 64'(op_b) & msk(4 * n);
        m_full[u] = m_a[u] + m_b[u] + 64'(cin);
        m_k[u]    = 0;
        m_run[u]  = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        logic [63:0] e_in0, e_in1, e_cin;
        int k;
        k = m_k[u];
        e_in0 = m_run[u] ? ((m_a[u] >> (4 * k)) & 64'hF) : 64'h0;
        e_in1 = m_run[u] ? ((m_b[u] >> (4 * k)) & 64'hF) : 64'h0;
        e_cin = m_run[u] ? (((m_full[u] ^ m_a[u] ^ m_b[u]) >> (4 * k)) & 64'h1) : 64'h0;
        chk($sformatf("u%0d busy", u), 64'((u == 0) ? busy4 : busy1), 64'(m_run[u]));
        chk($sformatf("u%0d done", u), 64'((u == 0) ? done4 : done1), 64'(m_done[u]));
        chk($sformatf("u%0d sum", u), (u == 0) ? 64'(sum4) : 64'(sum1), m_sum[u]);
        chk($sformatf("u%0d cout", u), 64'((u == 0) ? cout4 : cout1), 64'(m_cout[u]));
        chk($sformatf("u%0d ovf", u), 64'((u == 0) ? ovf4 : ovf1), 64'(m_ovf[u]));
        chk($sformatf("u%0d add_in_0", u), (u == 0) ? 64'(ain0_4) : 64'(ain0_1), e_in0);
        chk($sformatf("u%0d add_in_1", u), (u == 0) ? 64'(ain1_4) : 64'(ain1_1), e_in1);
        chk($sformatf("u%0d add_cin", u), 64'((u == 0) ? acin4 : acin1), e_cin);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [15:0] a, input logic [15:0] b, input logic c);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int nbusy, output logic [7:0] cseq);
    cyc   = 0;
    nbusy = 0;
    cseq  = '0;
    while (!done4 && cyc < 40) begin
      if (busy4) nbusy++;
      if (cyc < 8) cseq[cyc] = acin4;
      step();
      cyc++;
    end
    if (!done4) begin
      n_chk++;
      n_err++;
      $display("FAIL done timeout: got no done after %0d cycles expected done", cyc);
    end
  endtask

  initial begin
    int         cyc;
    int         nb;
    logic [7:0] cs;

    rst_n = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst busy", 64'(busy4), 64'h0);
    chk("rst done", 64'(done4), 64'h0);
    chk("rst sum", 64'(sum4), 64'h0);
    chk("rst cout", 64'(cout4), 64'h0);
    chk("rst ovf", 64'(ovf4), 64'h0);
    chk("rst add_in_0", 64'(ain0_4), 64'h0);
    chk("rst add_cin", 64'(acin4), 64'h0);
    chk("rst sum n1", 64'(sum1), 64'h0);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: basic add, latency and pulse widths
    req(16'h1234, 16'h0FFF, 1'b0);
    wait_done(cyc, nb, cs);
    chk("t1 done latency", 64'(cyc), 64'd4);
    chk("t1 busy cycles", 64'(nb), 64'd4);
    chk("t1 sum", 64'(sum4), 64'h2233);
    chk("t1 cout", 64'(cout4), 64'h0);
    chk("t1 ovf", 64'(ovf4), 64'h0);
    chk("t1 busy at done", 64'(busy4), 64'h0);
    step();
    chk("t1 done width", 64'(done4), 64'h0);

    // 2: full carry ripple
    req(16'hFFFF, 16'h0001, 1'b0);
    wait_done(cyc, nb, cs);
    chk("t2 carry seq", 64'(cs[3:0]), 64'hE);
    chk("t2 sum", 64'(sum4), 64'h0000);
    chk("t2 cout", 64'(cout4), 64'h1);
    chk("t2 ovf", 64'(ovf4), 64'h0);
    step();

    // 3: signed overflow both directions
    req(16'h7FFF, 16'h0001, 1'b0);
    wait_done(cyc, nb, cs);
    chk("t3a sum", 64'(sum4), 64'h8000);
    chk("t3a cout", 64'(cout4), 64'h0);
    chk("t3a ovf", 64'(ovf4), 64'h1);
    step();
    req(16'h8000, 16'h8000, 1'b0);
    wait_done(cyc, nb, cs);
    chk("t3b sum", 64'(sum4), 64'h0000);
    chk("t3b cout", 64'(cout4), 64'h1);
    chk("t3b ovf", 64'(ovf4), 64'h1);
    step();

    // 4: carry-in only; start held through RUN and DONE is not queued
    req(16'h0000, 16'h0000, 1'b1);
    op_a  = 16'hAAAA;
    op_b  = 16'h0000;
    cin   = 1'b0;
    start = 1'b1;
    wait_done(cyc, nb, cs);
    chk("t4 sum", 64'(sum4), 64'h0001);
    step();
    chk("t4 idle after done", 64'(busy4), 64'h0);
    step();
    chk("t4 second accept", 64'(busy4), 64'h1);
    start = 1'b0;
    wait_done(cyc, nb, cs);
    chk("t4 second sum", 64'(sum4), 64'hAAAA);
    step();

    // 5: asynchronous reset mid-operation
    req(16'h1111, 16'h2222, 1'b0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5 busy cleared", 64'(busy4), 64'h0);
    chk("t5 done cleared", 64'(done4), 64'h0);
    chk("t5 sum cleared", 64'(sum4), 64'h0);
    chk("t5 add_in_0 cleared", 64'(ain0_4), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req(16'h0001, 16'h0002, 1'b0);
    wait_done(cyc, nb, cs);
    chk("t5 fresh sum", 64'(sum4), 64'h0003);
    step();

    // 6: random requests with stray starts during RUN and random gaps
    for (int i = 0; i < 500; i++) begin
      req(16'($urandom), 16'($urandom), 1'($urandom));
      cyc = 0;
      while (!done4 && cyc < 40) begin
        start = ($urandom_range(0, 3) == 0);
        op_a  = 16'($urandom);
        step();
        cyc++;
      end
      start = 1'b0;
      if (!done4) begin
        n_chk++;
        n_err++;
        $display("FAIL rand done timeout: got no done in request %0d expected done", i);
      end
      step();
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (3) step();

    // single-nibble instance: done at E1
    req(16'h000F, 16'h0001, 1'b0);
    chk("n1 busy at E0", 64'(busy1), 64'h1);
    step();
    chk("n1 done at E1", 64'(done1), 64'h1);
    chk("n1 sum", 64'(sum1), 64'h0);
    chk("n1 cout", 64'(cout1), 64'h1);
    chk("n1 ovf", 64'(ovf1), 64'h0);
    wait_done(cyc, nb, cs);
    chk("n1 wide sum", 64'(sum4), 64'h0010);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
